// File: rtl/elevator_dispatcher.sv
// Hall-call dispatcher for a three-car bank: latches floor calls, hands each one
// to the nearest free car and follows that car through its move and door-dwell phases.
module elevator_dispatcher #(
  parameter int DOOR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] call_req,
  input  logic [2:0] car_pos1,
  input  logic [2:0] car_pos2,
  input  logic [2:0] car_pos3,
  output logic [2:0] target1,
  output logic [2:0] target2,
  output logic [2:0] target3,
  output logic [2:0] busy,
  output logic [7:0] pending,
  output logic       assign_valid,
  output logic [1:0] assign_car,
  output logic [2:0] assign_floor
);

  localparam logic [1:0] ST_FREE    = 2'd0;
  localparam logic [1:0] ST_MOVING  = 2'd1;
  localparam logic [1:0] ST_DWELL   = 2'd2;
  localparam logic [3:0] DWELL_LOAD = 4'(DOOR_CYCLES - 1);

  function automatic logic [2:0] floor_dist(input logic [2:0] a, input logic [2:0] b);
    if (a >= b) begin
      floor_dist = a - b;
    end else begin
      floor_dist = b - a;
    end
  endfunction

  logic [2:0] pos_s        [3];
  logic [1:0] state_r      [3];
  logic [1:0] state_nxt_s  [3];
  logic [2:0] target_r     [3];
  logic [2:0] target_nxt_s [3];
  logic [3:0] cnt_r        [3];
  logic [3:0] cnt_nxt_s    [3];
  logic [7:0] pending_r;
  logic [2:0] busy_r;
  logic       assign_valid_r;
  logic [1:0] assign_car_r;
  logic [2:0] assign_floor_r;

  logic [2:0] floor_sel_s;
  logic       car_found_s;
  logic [1:0] car_sel_s;
  logic [2:0] best_dist_s;
  logic       dispatch_s;
  logic [7:0] clr_s;

  assign pos_s[0] = car_pos1;
  assign pos_s[1] = car_pos2;
  assign pos_s[2] = car_pos3;

  // Lowest-index outstanding call is served first.
  always_comb begin
    floor_sel_s = 3'd0;
    for (int f = 7; f >= 0; f--) begin
      floor_sel_s = pending_r[f] ? 3'(f) : floor_sel_s;
    end
  end

  // Nearest free car; strict compare keeps ties on the lowest car index.
  always_comb begin
    car_found_s = 1'b0;
    car_sel_s   = 2'd0;
    best_dist_s = 3'd7;
    for (int i = 0; i < 3; i++) begin
      if ((state_r[i] == ST_FREE) &&
          (!car_found_s || (floor_dist(pos_s[i], floor_sel_s) < best_dist_s))) begin
        car_found_s = 1'b1;
        car_sel_s   = 2'(i);
        best_dist_s = floor_dist(pos_s[i], floor_sel_s);
      end else begin
        best_dist_s = best_dist_s;
      end
    end
  end

  assign dispatch_s = (pending_r != 8'd0) && car_found_s;
  assign clr_s      = dispatch_s ? (8'd1 << floor_sel_s) : 8'd0;

  // Per-car next state: FREE -> MOVING on selection, MOVING -> DWELL on arrival, DWELL -> FREE at count 0.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_nxt_s[i]  = state_r[i];
      target_nxt_s[i] = target_r[i];
      cnt_nxt_s[i]    = cnt_r[i];
      case (state_r[i])
        ST_FREE: begin
          if (dispatch_s && (car_sel_s == 2'(i))) begin
            state_nxt_s[i]  = ST_MOVING;
            target_nxt_s[i] = floor_sel_s;
          end else begin
            state_nxt_s[i] = ST_FREE;
          end
        end
        ST_MOVING: begin
          if (pos_s[i] == target_r[i]) begin
            state_nxt_s[i] = ST_DWELL;
            cnt_nxt_s[i]   = DWELL_LOAD;
          end else begin
            state_nxt_s[i] = ST_MOVING;
          end
        end
        ST_DWELL: begin
          if (cnt_r[i] == 4'd0) begin
            state_nxt_s[i] = ST_FREE;
          end else begin
            cnt_nxt_s[i] = cnt_r[i] - 4'd1;
          end
        end
        default: begin
          state_nxt_s[i] = ST_FREE;
          cnt_nxt_s[i]   = 4'd0;
        end
      endcase
    end
  end

  // Car state, targets and busy flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        state_r[i]  <= ST_FREE;
        target_r[i] <= 3'd0;
        cnt_r[i]    <= 4'd0;
      end
      busy_r <= 3'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_r[i]  <= state_nxt_s[i];
        target_r[i] <= target_nxt_s[i];
        cnt_r[i]    <= cnt_nxt_s[i];
        busy_r[i]   <= (state_nxt_s[i] != ST_FREE);
      end
    end
  end

  // Pending calls and the assignment report; a same-cycle re-request beats the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_r      <= 8'd0;
      assign_valid_r <= 1'b0;
      assign_car_r   <= 2'd0;
      assign_floor_r <= 3'd0;
    end else begin
      pending_r      <= (pending_r & ~clr_s) | call_req;
      assign_valid_r <= dispatch_s;
      if (dispatch_s) begin
        assign_car_r   <= car_sel_s + 2'd1;
        assign_floor_r <= floor_sel_s;
      end else begin
        assign_car_r   <= assign_car_r;
        assign_floor_r <= assign_floor_r;
      end
    end
  end

  assign target1      = target_r[0];
  assign target2      = target_r[1];
  assign target3      = target_r[2];
  assign busy         = busy_r;
  assign pending      = pending_r;
  assign assign_valid = assign_valid_r;
  assign assign_car   = assign_car_r;
  assign assign_floor = assign_floor_r;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Scoreboard bench for elevator_dispatcher: expected {car,floor} assignments are queued
// as calls are driven and compared against each assign_valid pulse.
module tb_elevator_dispatcher;

  localparam int DOOR_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] call_req = 8'd0;
  logic [2:0] car_pos1 = 3'd0;
  logic [2:0] car_pos2 = 3'd0;
  logic [2:0] car_pos3 = 3'd0;
  logic [2:0] target1, target2, target3;
  logic [2:0] busy;
  logic [7:0] pending;
  logic       assign_valid;
  logic [1:0] assign_car;
  logic [2:0] assign_floor;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  elevator_dispatcher #(.DOOR_CYCLES(DOOR_CYCLES)) dut (
    .clk(clk), .rst(rst), .call_req(call_req),
    .car_pos1(car_pos1), .car_pos2(car_pos2), .car_pos3(car_pos3),
    .target1(target1), .target2(target2), .target3(target3),
    .busy(busy), .pending(pending), .assign_valid(assign_valid),
    .assign_car(assign_car), .assign_floor(assign_floor)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check(tag, {target1, target2, target3, busy, pending, assign_valid, assign_car, assign_floor}, 32'd0);
  endtask

  // Scoreboard: every assignment pulse must match the oldest expected {car,floor}.
  always @(posedge clk) begin
    #1;
    if (assign_valid) begin
      if (exp_q.size() == 0) begin
        check("assign_unexpected", exp_q.size(), 32'd1);
      end else begin
        check("assign", {assign_car, assign_floor}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Asynchronous reset mid-cycle with random inputs
    #3;
    call_req = 8'($urandom);
    car_pos1 = 3'($urandom_range(0, 7));
    car_pos2 = 3'($urandom_range(0, 7));
    car_pos3 = 3'($urandom_range(0, 7));
    rst = 1'b0;
    #1;
    check_zero("reset_async");
    call_req = 8'd0; car_pos1 = 3'd0; car_pos2 = 3'd0; car_pos3 = 3'd0;
    tick(); tick();
    #2 rst = 1'b1;
    repeat (3) tick();
    check("idle_no_assign", assign_valid, 32'd0);
    check("idle_pending", pending, 32'd0);

    // Single call, three-way tie goes to car 1
    call_req = 8'h20; exp_q.push_back({2'd1, 3'd5});
    tick(); call_req = 8'd0;
    check("sc_pending", pending, 32'h20);
    check("sc_busy_pre", busy, 32'd0);
    tick();
    check("sc_target1", target1, 32'd5);
    check("sc_busy", busy, 32'b001);
    check("sc_pending_clr", pending, 32'd0);
    repeat (2) tick();
    check("sc_busy_moving", busy, 32'b001);
    car_pos1 = 3'd5; n = 0;
    while (busy[0] && n < 40) begin tick(); n++; end
    check("sc_dwell_edges", n, 32'(1 + DOOR_CYCLES));

    // Nearest car wins
    car_pos1 = 3'd0; car_pos2 = 3'd6; car_pos3 = 3'd3;
    call_req = 8'h80; exp_q.push_back({2'd2, 3'd7});
    tick(); call_req = 8'd0;
    tick();
    check("nc_target2", target2, 32'd7);
    check("nc_pending", pending, 32'd0);
    check("nc_busy", busy, 32'b010);
    check("nc_target1_hold", target1, 32'd5);
    car_pos2 = 3'd7; n = 0;
    while (busy[1] && n < 40) begin tick(); n++; end
    check("nc_release", busy, 32'd0);

    // Two simultaneous calls, served one per cycle
    car_pos1 = 3'd0; car_pos2 = 3'd0; car_pos3 = 3'd0;
    call_req = 8'h44; exp_q.push_back({2'd1, 3'd2}); exp_q.push_back({2'd2, 3'd6});
    tick(); call_req = 8'd0;
    check("sim_pending", pending, 32'h44);
    tick();
    check("sim_target1", target1, 32'd2);
    check("sim_pending1", pending, 32'h40);
    check("sim_valid1", assign_valid, 32'd1);
    tick();
    check("sim_target2", target2, 32'd6);
    check("sim_pending2", pending, 32'd0);
    check("sim_valid2", assign_valid, 32'd1);
    check("sim_busy", busy, 32'b011);
    tick();
    check("sim_valid_end", assign_valid, 32'd0);

    // All cars busy: call waits until car 3 frees
    call_req = 8'h02; exp_q.push_back({2'd3, 3'd1});
    tick(); call_req = 8'd0;
    tick();
    check("ab_busy_all", busy, 32'b111);
    call_req = 8'h10;
    tick(); call_req = 8'd0;
    repeat (3) tick();
    check("ab_pending_held", pending, 32'h10);
    check("ab_target3", target3, 32'd1);
    exp_q.push_back({2'd3, 3'd4});
    car_pos3 = 3'd1; n = 0;
    while (busy[2] && n < 40) begin tick(); n++; end
    check("ab_freed", busy, 32'b011);
    check("ab_pending_at_free", pending, 32'h10);
    tick();
    check("ab_target3_new", target3, 32'd4);
    check("ab_busy_again", busy, 32'b111);
    check("ab_pending_clr", pending, 32'd0);

    // Reset while cars are moving
    #2;
    call_req = 8'($urandom);
    rst = 1'b0;
    #1;
    check_zero("rst_mid_move");
    call_req = 8'd0;
    tick();
    #2 rst = 1'b1;
    repeat (3) tick();
    check_zero("rst_release");

    // Re-request on the dispatch edge keeps the call pending
    car_pos3 = 3'd0;
    call_req = 8'h08; exp_q.push_back({2'd1, 3'd3});
    tick();
    exp_q.push_back({2'd2, 3'd3});
    tick(); call_req = 8'd0;
    check("col_pending", pending, 32'h08);
    check("col_target1", target1, 32'd3);
    check("col_busy1", busy, 32'b001);
    tick();
    check("col_target2", target2, 32'd3);
    check("col_pending_clr", pending, 32'd0);
    check("col_busy2", busy, 32'b011);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_dispatcher.md
# elevator_dispatcher

Hall-call dispatcher for the three-car `top` elevator bank. It latches floor call requests, picks the nearest free car for each call, and drives that car's 3-bit target floor into the `floor` input of the matching `elevator` instance. It tracks each car through move and door-dwell phases by watching the car's reported position (`out`), so only free cars receive new work.

## Interface
Parameters:
- `DOOR_CYCLES`, default 4: cycles a car dwells at its target before it is free again. Legal range is 1..15.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `call_req`  in  8  hall-call pulses, one bit per floor. Bit F high in a cycle requests floor F.
- `car_pos1`, `car_pos2`, `car_pos3`  in  3 each  current floor of each car, wired from `out1`..`out3`.
- `target1`, `target2`, `target3`  out  3 each  target floor per car, wired to `floor1`..`floor3`. Registered.
- `busy`  out  3  bit i-1 is high while car i is not FREE. Registered.
- `pending`  out  8  outstanding, unassigned calls. Registered.
- `assign_valid`  out  1  one-cycle pulse, high in the cycle after an assignment edge.
- `assign_car`  out  2  car that received the assignment, encoded 1..3. Valid while `assign_valid` is high.
- `assign_floor`  out  3  floor that was assigned. Valid while `assign_valid` is high.

## Operation
- Pending register update: `pending <= (pending & ~clr) | call_req`.
  - `clr` is the one-hot floor assigned this cycle.
  - If `call_req` sets the same bit that is being cleared, the set wins and the call stays pending, giving a duplicate service.
  - Calls for a floor that is already a car's target are not merged.
- Per-car FSM, one per car:
  - **FREE**
    - `target` holds its last value.
    - Goes to MOVING when this car is selected. `target` takes the assigned floor on the same edge.
  - **MOVING**
    - When `car_pos == target` at a rising edge: go to DWELL and load the dwell counter with `DOOR_CYCLES-1`.
    - If the car is already at the assigned floor, DWELL is entered on the edge after assignment.
  - **DWELL**
    - The counter decrements each cycle.
    - At 0, go to FREE on the next edge.
    - DWELL lasts exactly `DOOR_CYCLES` cycles.
- Dispatch decision, combinational from registered state, at most one per cycle. It fires when `pending != 0` and at least one car is FREE.
  - Floor choice: the lowest-index set bit of `pending`.
  - Car choice: the FREE car with minimum `|car_pos - F|`.
    - Distance is an unsigned 3-bit value, computed as larger minus smaller.
    - Ties go to the lowest car index.
- On the dispatch edge, the following all happen together:
  - `pending[F]` is cleared.
  - The chosen car goes to MOVING.
  - `target` takes F.
  - `assign_valid`/`assign_car`/`assign_floor` are registered.
- If no car is FREE, pending calls wait and no pulse is issued.
- Reset, asynchronous, at any time including mid-move or mid-dwell:
  - `pending` = 0.
  - All FSMs go to FREE.
  - `target1..3` = 0.
  - `busy` = 0.
  - `assign_valid` = 0, `assign_car` = 0, `assign_floor` = 0.
  - Dwell counters = 0.
- Reset release: normal operation starts at the first rising edge with `rst` high.

## Timing
- `call_req[F]` high before edge k: `pending[F]` = 1 after edge k.
  - Earliest dispatch is at edge k+1: `target`, `busy` and `assign_valid` change after edge k+1.
  - Call-to-target latency is 2 edges.
- `assign_valid` is high for exactly one cycle per assignment.
  - Back-to-back assignments give a continuous high with changing `assign_car`/`assign_floor`.
- A car freed at edge j is eligible for dispatch at edge j+1. DWELL→FREE and a new assignment never happen on the same edge.
- `busy[i]` rises on the dispatch edge and falls on the DWELL→FREE edge.

## Test plan
- **Reset:**
  - Stimulus: assert `rst`=0 mid-cycle with random inputs.
  - Response: every output goes to 0 immediately, without waiting for a clock edge.
  - Stimulus: release reset.
  - Response: no `assign_valid` until a call arrives.
- **Single call, tie-break:**
  - Stimulus: all `car_pos`=0, pulse `call_req`=8'h20.
  - Response: 2 edges later `target1`=5, `busy`=3'b001, `assign_car`=1, `assign_floor`=5.
  - Stimulus: drive `car_pos1`=5.
  - Response: `busy[0]` drops exactly 1+`DOOR_CYCLES` edges after arrival is sampled.
- **Nearest car:**
  - Stimulus: `car_pos1`=0, `car_pos2`=6, `car_pos3`=3, `call_req`=8'h80.
  - Response: `assign_car`=2, `target2`=7, `pending`=0 after assignment.
- **Simultaneous calls:**
  - Stimulus: all cars at 0, `call_req`=8'h44 for one cycle.
  - Response: floor 2 goes to car 1 at edge k+1; floor 6 goes to car 2 at edge k+2; `assign_valid` high for 2 cycles.
- **All busy:**
  - Stimulus: occupy all three cars, then pulse call for floor 4.
  - Response: `pending`=8'h10 held.
  - Stimulus: car 3 finishes dwell.
  - Response: floor 4 is assigned to car 3 one edge after `busy[2]` falls.
- **Set/clear collision and mid-operation reset:**
  - Stimulus: re-pulse `call_req[3]` on the edge floor 3 is dispatched.
  - Response: `pending[3]` stays 1 and is dispatched again.
  - Stimulus: reset during MOVING.
  - Response: `target` returns to 0 and the car is FREE.
